// File: rtl/rsg_param.sv
// rsg_param: parametrised random digit sequence generator, flasher and checker for the memory game
// Ports: clock/rst (async active-high), start/logout/level_num from the level controller,
//   digit_in/digit_valid/replay from the player, flash_num {on,digit} to the display,
//   seq_len/input_idx progress, busy/input_phase/win/loose status; all outputs registered.
// Optional feature: define RSG_REPLAY_EN to allow one sequence replay per round.
module rsg_param #(
  parameter int          DIGIT_W   = 4,
  parameter int          MAX_DIGIT = 9,
  parameter int          DEPTH     = 16,
  parameter int          BASE_LEN  = 3,
  parameter int          FLASH_CYC = 50000000,
  parameter int          GAP_CYC   = 25000000,
  parameter int          INPUT_TO  = 250000000,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic               logout,
  input  logic [3:0]         level_num,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               replay,
  output logic [DIGIT_W:0]   flash_num,
  output logic [4:0]         seq_len,
  output logic [4:0]         input_idx,
  output logic               busy,
  output logic               input_phase,
  output logic               win,
  output logic               loose
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q;
  logic [DIGIT_W-1:0] mem_q [DEPTH];
  logic [4:0] idx_q, idx_d, len_q, len_d, in_q, in_d, len_new;
  logic [31:0] tmr_q, tmr_d, len_sum;
  logic [DIGIT_W-1:0] raw, digit;
  logic [DIGIT_W:0] flash_q;
  logic busy_q, inp_q, win_q, loose_q, rep_req;
  assign raw = lfsr_q[DIGIT_W-1:0];
  assign digit = raw > DIGIT_W'(MAX_DIGIT) ? raw - DIGIT_W'(MAX_DIGIT + 1) : raw;
  assign len_sum = 32'(BASE_LEN) + 32'(level_num);
  assign len_new = len_sum > 32'(DEPTH) ? 5'(DEPTH) : len_sum[4:0];
`ifdef RSG_REPLAY_EN
  logic rep_q;
  assign rep_req = replay && !rep_q && in_q == 5'd0;
  always_ff @(posedge clock or posedge rst)
    if (rst) rep_q <= 1'b0;
    else rep_q <= (state_d == GEN && state_q != GEN) ? 1'b0 : rep_q | (state_q == INPUT && state_d == SHOW_ON);
`else
  logic unused_replay;
  assign unused_replay = replay;
  assign rep_req = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    in_d = in_q;
    tmr_d = tmr_q;
    if (logout) begin
      state_d = IDLE;
      idx_d = '0;
      len_d = '0;
      in_d = '0;
      tmr_d = '0;
    end else case (state_q)
      IDLE, WIN, LOSE: if (start) begin
        state_d = GEN;
        idx_d = '0;
        in_d = '0;
        len_d = len_new;
      end
      GEN: if (idx_q == len_q - 5'd1) begin
        state_d = SHOW_ON;
        idx_d = '0;
        tmr_d = 32'(FLASH_CYC - 1);
      end else idx_d = idx_q + 5'd1;
      SHOW_ON: if (tmr_q == '0) begin
        state_d = SHOW_OFF;
        tmr_d = 32'(GAP_CYC - 1);
      end else tmr_d = tmr_q - 32'd1;
      SHOW_OFF: if (tmr_q != '0) tmr_d = tmr_q - 32'd1;
      else if (idx_q == len_q - 5'd1) begin
        state_d = INPUT;
        in_d = '0;
        tmr_d = 32'(INPUT_TO);
      end else begin
        state_d = SHOW_ON;
        idx_d = idx_q + 5'd1;
        tmr_d = 32'(FLASH_CYC - 1);
      end
      INPUT: if (digit_valid) begin
        if (digit_in != mem_q[in_q[AW-1:0]]) state_d = LOSE;
        else if (in_q == len_q - 5'd1) state_d = WIN;
        else begin
          in_d = in_q + 5'd1;
          tmr_d = 32'(INPUT_TO);
        end
      end else if (rep_req) begin
        state_d = SHOW_ON;
        idx_d = '0;
        tmr_d = 32'(FLASH_CYC - 1);
      end else if (tmr_q <= 32'd1) state_d = LOSE;
      else tmr_d = tmr_q - 32'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (state_q == GEN) mem_q[idx_q[AW-1:0]] <= digit;
  // A one-digit round leaves GEN on the same edge that writes entry 0, so bypass it
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      idx_q <= '0;
      len_q <= '0;
      in_q <= '0;
      tmr_q <= '0;
      flash_q <= '0;
      busy_q <= 1'b0;
      inp_q <= 1'b0;
      win_q <= 1'b0;
      loose_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_q[0] ? (lfsr_q >> 1) ^ 16'hB400 : lfsr_q >> 1;
      idx_q <= idx_d;
      len_q <= len_d;
      in_q <= in_d;
      tmr_q <= tmr_d;
      flash_q <= state_d == SHOW_ON ? {1'b1, (state_q == GEN && len_q == 5'd1) ? digit : mem_q[idx_d[AW-1:0]]} : '0;
      busy_q <= state_d inside {GEN, SHOW_ON, SHOW_OFF, INPUT};
      inp_q <= state_d == INPUT;
      win_q <= state_d == WIN;
      loose_q <= state_d == LOSE;
    end
  assign flash_num = flash_q;
  assign seq_len = len_q;
  assign input_idx = in_q;
  assign busy = busy_q;
  assign input_phase = inp_q;
  assign win = win_q;
  assign loose = loose_q;
endmodule

// File: tb/tb_rsg_param.sv
// tb_rsg_param: scoreboard bench for rsg_param with directed rounds and an LFSR reference model
module tb_rsg_param;
  localparam int DW = 4, F = 4, G = 2, TO = 8, WIN_EV = 100, LOSE_EV = 200;
  logic clock = 0, rst = 1, start = 0, logout = 0, digit_valid = 0, replay = 0;
  logic [3:0] level_num = 0;
  logic [DW-1:0] digit_in = 0;
  logic [DW:0] flash_num;
  logic [4:0] seq_len, input_idx;
  logic busy, input_phase, win, loose;
  int checks = 0, failures = 0;
  int exp_q[$];
  int seq[16];
  logic [15:0] m_lfsr;
  int on_run = 0;
  logic p_on = 0, p_win = 0, p_loose = 0;
  rsg_param #(.DIGIT_W(DW), .MAX_DIGIT(9), .DEPTH(16), .BASE_LEN(3), .FLASH_CYC(F),
              .GAP_CYC(G), .INPUT_TO(TO), .SEED(16'hACE1)) dut (
    .clock(clock), .rst(rst), .start(start), .logout(logout), .level_num(level_num),
    .digit_in(digit_in), .digit_valid(digit_valid), .replay(replay), .flash_num(flash_num),
    .seq_len(seq_len), .input_idx(input_idx), .busy(busy), .input_phase(input_phase),
    .win(win), .loose(loose));
  always #5 clock = ~clock;
  function automatic logic [15:0] step(logic [15:0] s);
    return s[0] ? (s >> 1) ^ 16'hB400 : s >> 1;
  endfunction
  function automatic int fold(logic [3:0] r);
    return int'(r) > 9 ? int'(r) - 10 : int'(r);
  endfunction
  always @(posedge clock or posedge rst) m_lfsr <= rst ? 16'hACE1 : step(m_lfsr);
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic sb_pop(string nm, int code);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event %0d with empty scoreboard", nm, code);
    end else chk(nm, code, exp_q.pop_front());
  endtask
  always @(negedge clock)
    if (rst) begin
      on_run = 0;
      p_on = 0;
      p_win = 0;
      p_loose = 0;
    end else begin
      if (flash_num[DW] && !p_on) begin
        sb_pop("sb_flash", int'(flash_num[DW-1:0]));
        chk("digit_range", int'(flash_num[DW-1:0] <= 4'd9), 1);
      end
      if (flash_num[DW]) on_run++;
      else if (p_on) begin
        chk("flash_len", on_run, F);
        on_run = 0;
      end
      if (win && !p_win) sb_pop("sb_win", WIN_EV);
      if (loose && !p_loose) sb_pop("sb_loose", LOSE_EV);
      p_on = flash_num[DW];
      p_win = win;
      p_loose = loose;
    end
  function automatic logic sig(int w);
    return w == 0 ? flash_num[DW] : w == 1 ? input_phase : loose;
  endfunction
  task automatic wait_ev(int which, string nm, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sig(which) && n < 400);
    if (!sig(which)) begin
      checks++;
      failures++;
      $display("FAIL %s: timed out after %0d cycles", nm, n);
    end
  endtask
  task automatic start_round(int lvl, int len);
    logic [15:0] s;
    start = 1;
    level_num = 4'(lvl);
    @(negedge clock);
    start = 0;
    chk("busy_on_start", busy, 1);
    chk("seq_len", seq_len, len);
    chk("input_idx_clr", input_idx, 0);
    s = m_lfsr;
    for (int i = 0; i < len; i++) begin
      seq[i] = fold(s[3:0]);
      exp_q.push_back(seq[i]);
      s = step(s);
    end
  endtask
  task automatic give(int d);
    digit_in = 4'(d);
    digit_valid = 1;
    @(negedge clock);
    digit_valid = 0;
  endtask
  task automatic chk_all_zero(string nm);
    chk({nm, "_flash"}, flash_num, 0);
    chk({nm, "_len"}, seq_len, 0);
    chk({nm, "_idx"}, input_idx, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_inp"}, input_phase, 0);
    chk({nm, "_win"}, win, 0);
    chk({nm, "_loose"}, loose, 0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    rst = 0;
    @(negedge clock);
    chk("idle_busy", busy, 0);
    start_round(2, 5);
    wait_ev(0, "first_flash", n);
    chk("first_flash_lat", n, 5);
    wait_ev(1, "input_entry", n);
    chk("input_entry_lat", n, 5 * (F + G));
    for (int i = 0; i < 4; i++) begin
      give(seq[i]);
      chk("match_idx", input_idx, i + 1);
      chk("no_early_win", win, 0);
    end
    exp_q.push_back(WIN_EV);
    give(seq[4]);
    chk("win", win, 1);
    chk("busy_after_win", busy, 0);
    start_round(0, 3);
    wait_ev(0, "first_flash", n);
    chk("first_flash_lat", n, 3);
    start = 1;
    level_num = 7;
    digit_in = 0;
    digit_valid = 1;
    @(negedge clock);
    start = 0;
    digit_valid = 0;
    chk("start_ignored_len", seq_len, 3);
    chk("start_ignored_busy", busy, 1);
    wait_ev(1, "input_entry", n);
    chk("input_entry_lat", n, 3 * (F + G) - 1);
    give(seq[0]);
    give(seq[1]);
    chk("match_idx", input_idx, 2);
    exp_q.push_back(LOSE_EV);
    give((seq[2] + 1) % 10);
    chk("wrong_loose", loose, 1);
    chk("wrong_idx_hold", input_idx, 2);
    chk("wrong_inp", input_phase, 0);
    start_round(15, 16);
    wait_ev(0, "first_flash", n);
    chk("first_flash_lat", n, 16);
    wait_ev(1, "input_entry", n);
    chk("input_entry_lat", n, 16 * (F + G));
    repeat (4) @(negedge clock);
    give(seq[0]);
    chk("reload_idx", input_idx, 1);
    chk("reload_no_loose", loose, 0);
    exp_q.push_back(LOSE_EV);
    wait_ev(2, "timeout", n);
    chk("reload_timeout_lat", n, TO);
    chk("timeout_idx", input_idx, 1);
    start_round(0, 3);
    wait_ev(0, "first_flash", n);
    wait_ev(1, "input_entry", n);
    give(seq[0]);
    give(seq[1]);
    logout = 1;
    digit_in = 4'(seq[2]);
    digit_valid = 1;
    @(negedge clock);
    logout = 0;
    digit_valid = 0;
    chk_all_zero("logout");
    repeat (3) @(negedge clock);
    chk("idle_hold_busy", busy, 0);
    start_round(0, 3);
    wait_ev(0, "first_flash", n);
    wait_ev(1, "input_entry", n);
`ifdef RSG_REPLAY_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
    replay = 1;
    @(negedge clock);
    replay = 0;
    chk("replay_inp", input_phase, 0);
    chk("replay_flash_on", flash_num[DW], 1);
    wait_ev(1, "replay_entry", n);
    chk("replay_entry_lat", n, 3 * (F + G));
`endif
    replay = 1;
    @(negedge clock);
    replay = 0;
    chk("replay_ignored_inp", input_phase, 1);
    chk("replay_ignored_flash", flash_num, 0);
    give(seq[0]);
    give(seq[1]);
    exp_q.push_back(WIN_EV);
    give(seq[2]);
    chk("replay_round_win", win, 1);
    start_round(1, 4);
    wait_ev(0, "first_flash", n);
    @(negedge clock);
    #2 rst = 1;
    #1 chk_all_zero("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clock);
    rst = 0;
    repeat (3) @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_flash", flash_num, 0);
    start_round(1, 4);
    wait_ev(0, "first_flash", n);
    chk("first_flash_lat", n, 4);
    wait_ev(1, "input_entry", n);
    chk("input_entry_lat", n, 4 * (F + G));
    exp_q.push_back(LOSE_EV);
    wait_ev(2, "timeout", n);
    chk("timeout_lat", n, TO);
    chk("timeout_idx0", input_idx, 0);
    @(negedge clock);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
